// File: rtl/rr_merge.sv
// Round-robin merge of N_MASTERS request/response channels onto one shared slave.
// Request word: bit 0 = valid, upper bits = payload. Response word: bit 0 = ready, upper = rdata.
module rr_merge #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned REQ_W     = 17,
  parameter int unsigned RESP_W    = 9
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp,
  output logic [N_MASTERS-1:0]          grant,
  output logic                          busy,
  output logic                          timeout
);

  localparam int unsigned PtrW = $clog2(N_MASTERS);
  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e               state_q, state_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic                 timeout_q, timeout_d;

  logic [N_MASTERS-1:0] valid;
  logic [PtrW-1:0]      pick, gidx, ptr_next;
  logic                 pick_found;
  int unsigned          idx;
  logic [REQ_W-1:0]     g_req;

  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      valid[i] = m_req[i*REQ_W];
    end
  end

  // Round-robin search starting at ptr, wrapping modulo N_MASTERS.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      idx = (32'(ptr_q) + k) % N_MASTERS;
      if (!pick_found && valid[idx[PtrW-1:0]]) begin
        pick_found = 1'b1;
        pick       = idx[PtrW-1:0];
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (grant_q[i]) begin
        gidx = PtrW'(i);
      end
    end
  end

  assign ptr_next = (gidx == PtrW'(N_MASTERS - 1)) ? '0 : gidx + PtrW'(1);
  assign g_req    = m_req[gidx*REQ_W +: REQ_W];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    s_req     = '0;
    // rdata is broadcast; only the owner ever sees ready.
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      m_resp[i*RESP_W +: RESP_W] = {s_resp[RESP_W-1:1], 1'b0};
    end

    unique case (state_q)
      StIdle: begin
        cnt_d   = '0;
        grant_d = '0;
        if (pick_found) begin
          grant_d[pick] = 1'b1;
          state_d       = StBusy;
        end
      end
      StBusy: begin
        s_req                         = g_req;
        m_resp[gidx*RESP_W +: RESP_W] = s_resp;
        if (s_resp[0] || !g_req[0]) begin
          // Completion, or the owner withdrew its request.
          state_d = StIdle;
          ptr_d   = ptr_next;
          grant_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          s_req[0]                      = 1'b0;
          m_resp[gidx*RESP_W +: RESP_W] = RESP_W'(1);
          timeout_d                     = 1'b1;
          state_d                       = StIdle;
          ptr_d                         = ptr_next;
          grant_d                       = '0;
          cnt_d                         = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q == StBusy);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_merge.sv
// Bench for rr_merge: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against an owner/pointer/age model of the arbiter.
module tb_rr_merge;
  localparam int N  = 3;
  localparam int T  = 8;
  localparam int RW = 17;
  localparam int SW = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N*RW-1:0] m_req = '0;
  logic [N*SW-1:0] m_resp;
  logic [RW-1:0]   s_req;
  logic [SW-1:0]   s_resp = '0;
  logic [N-1:0]    grant;
  logic            busy;
  logic            timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_merge #(
    .N_MASTERS(N),
    .TIMEOUT  (T),
    .REQ_W    (RW),
    .RESP_W   (SW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m_req  (m_req),
    .m_resp (m_resp),
    .s_req  (s_req),
    .s_resp (s_resp),
    .grant  (grant),
    .busy   (busy),
    .timeout(timeout)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] p);
    m_req[i*RW +: RW] = {p, v};
  endtask

  task automatic clear_reqs();
    m_req = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // Model: owner (-1 = nobody), round-robin pointer, age of current transfer, pending pulse.
  int mo = -1, mp = 0, mc = 0;
  bit mt = 1'b0, mok = 1'b0;
  int no, np, nc;
  bit nt;

  always @(negedge clk) begin
    logic [RW-1:0]   e_sreq;
    logic [N*SW-1:0] e_resp;
    logic [N-1:0]    e_grant;
    logic [RW-1:0]   r;
    int              cand;
    e_sreq  = '0;
    e_grant = '0;
    no = mo; np = mp; nc = mc; nt = 1'b0;
    for (int i = 0; i < N; i++) e_resp[i*SW +: SW] = {s_resp[SW-1:1], 1'b0};
    if (mo < 0) begin
      nc = 0;
      for (int k = 0; k < N; k++) begin
        cand = (mp + k) % N;
        if (no < 0 && m_req[cand*RW]) no = cand;
      end
    end else begin
      e_grant[mo]         = 1'b1;
      r                   = m_req[mo*RW +: RW];
      e_sreq              = r;
      e_resp[mo*SW +: SW] = s_resp;
      if (s_resp[0] || !r[0]) begin
        no = -1; np = (mo + 1) % N; nc = 0;
      end else if (mc == T - 1) begin
        e_sreq[0]           = 1'b0;
        e_resp[mo*SW +: SW] = SW'(1);
        no = -1; np = (mo + 1) % N; nc = 0; nt = 1'b1;
      end else begin
        nc = mc + 1;
      end
    end
    if (mok) begin
      chk("m_grant", grant, e_grant);
      chk("m_busy", busy, (mo >= 0));
      chk("m_timeout", timeout, mt);
      chk("m_s_req", s_req, e_sreq);
      chk("m_m_resp", m_resp, e_resp);
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      mo <= -1; mp <= 0; mc <= 0; mt <= 1'b0; mok <= 1'b1;
    end else begin
      mo <= no; mp <= np; mc <= nc; mt <= nt;
    end
  end

  int exp034[7] = '{1, 0, 2, 0, 4, 0, 1};

  initial begin
    // Reset state
    rst = 1'b0;
    step(); step();
    look();
    chk("rst_grant", grant, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_s_req", s_req, 17'h0);

    // Single master, slave ready on the second busy cycle
    step();
    rst = 1'b1;
    set_req(0, 1'b1, 16'h1234);
    look();
    chk("idle_s_req", s_req, 17'h0);
    chk("idle_m0_ready", m_resp[0], 1'b0);
    step();
    look();
    chk("m0_grant", grant, 3'b001);
    chk("m0_busy", busy, 1'b1);
    chk("m0_s_req", s_req, 17'h02469);
    chk("m0_noready", m_resp[0], 1'b0);
    step();
    s_resp = 9'h0B5;
    look();
    chk("m0_resp", m_resp[8:0], 9'h0B5);
    chk("m1_bcast", m_resp[17:9], 9'h0B4);
    step();
    s_resp = '0;
    clear_reqs();
    look();
    chk("m0_done_busy", busy, 1'b0);
    chk("m0_done_grant", grant, 3'b000);
    step();
    set_req(0, 1'b1, 16'h1111);
    set_req(1, 1'b1, 16'h2222);
    look();
    step();
    s_resp = 9'h001;
    look();
    chk("ptr1_grant", grant, 3'b010);
    step();
    s_resp = '0;
    clear_reqs();
    look();

    // All masters valid, slave always ready
    step();
    rst = 1'b0;
    look();
    step();
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 16'(16'hA000 + i));
    s_resp = 9'h001;
    look();
    for (int j = 0; j < 7; j++) begin
      step();
      look();
      chk("rr_order", grant, exp034[j]);
    end
    step();
    clear_reqs();
    s_resp = '0;
    rst = 1'b0;
    look();

    // Timeout abort on m2
    step();
    rst = 1'b1;
    set_req(2, 1'b1, 16'h0BEE);
    s_resp = 9'h0EE;
    look();
    for (int k = 1; k <= 8; k++) begin
      step();
      look();
      if (k == 1) chk("to_grant", grant, 3'b100);
      if (k == 8) begin
        chk("to_m2_resp", m_resp[26:18], 9'h001);
        chk("to_s_valid", s_req[0], 1'b0);
        chk("to_no_pulse_yet", timeout, 1'b0);
        chk("to_m0_bcast", m_resp[8:0], 9'h0EE);
      end
    end
    step();
    set_req(0, 1'b1, 16'h0001);
    look();
    chk("to_pulse", timeout, 1'b1);
    chk("to_idle_grant", grant, 3'b000);
    chk("to_idle_busy", busy, 1'b0);
    step();
    look();
    chk("to_ptr0_grant", grant, 3'b001);
    chk("to_pulse_gone", timeout, 1'b0);
    step();
    clear_reqs();
    s_resp = '0;
    rst = 1'b0;
    look();

    // Ready coinciding with the timeout condition
    step();
    rst = 1'b1;
    set_req(1, 1'b1, 16'h0555);
    look();
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 8) s_resp = 9'h187;
      look();
      if (k == 1) chk("race_grant", grant, 3'b010);
      if (k == 8) begin
        chk("race_m1_resp", m_resp[17:9], 9'h187);
        chk("race_s_valid", s_req[0], 1'b1);
      end
    end
    step();
    s_resp = '0;
    clear_reqs();
    look();
    chk("race_no_pulse", timeout, 1'b0);
    chk("race_idle", busy, 1'b0);

    // Reset mid-transfer
    step();
    rst = 1'b0;
    look();
    step();
    rst = 1'b1;
    set_req(1, 1'b1, 16'h0777);
    look();
    step();
    look();
    chk("mrst_grant", grant, 3'b010);
    step();
    rst = 1'b0;
    look();
    step();
    rst = 1'b1;
    look();
    chk("mrst_grant0", grant, 3'b000);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_s_valid", s_req[0], 1'b0);
    chk("mrst_m1_ready", m_resp[9], 1'b0);
    step();
    look();
    chk("mrst_regrant", grant, 3'b010);

    // Owner withdraws; pointer wraps to m0
    step();
    rst = 1'b0;
    clear_reqs();
    look();
    step();
    rst = 1'b1;
    set_req(1, 1'b1, 16'h0042);
    look();
    step();
    set_req(1, 1'b0, 16'h0042);
    set_req(0, 1'b1, 16'h0099);
    look();
    chk("drop_grant", grant, 3'b010);
    step();
    look();
    chk("drop_idle", busy, 1'b0);
    chk("drop_no_pulse", timeout, 1'b0);
    step();
    look();
    chk("drop_wrap_grant", grant, 3'b001);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int  rp;
      bit  v;
      step();
      rp = ((c / 300) % 3 == 0) ? 0 : (((c / 300) % 3 == 1) ? 30 : 70);
      for (int i = 0; i < N; i++) begin
        v = m_req[i*RW];
        if (v) begin
          if ($urandom_range(99) < 8) v = 1'b0;
        end else if ($urandom_range(99) < 40) begin
          v = 1'b1;
        end
        set_req(i, v, 16'($urandom));
      end
      s_resp = {8'($urandom), ($urandom_range(99) < rp)};
      rst = ($urandom_range(999) < 5) ? 1'b0 : 1'b1;
      look();
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_merge.md
RR_MERGE -- requirements
Module: rr_merge

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, meaning the number of requesting masters (range 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of BUSY cycles allowed without slave ready (range 2..65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port m_req, input, N_MASTERS*`REQ_W bits: master requests, with master i at `req(i).
REQ-006 SHALL have port m_resp, output, N_MASTERS*`RESP_W bits: master responses, with master i at `resp(i).
REQ-007 SHALL have port s_req, output, `REQ_W bits: request to the shared slave.
REQ-008 SHALL have port s_resp, input, `RESP_W bits: response from the shared slave.
REQ-009 SHALL have port grant, output, N_MASTERS bits: one-hot current owner, all zeros when idle.
REQ-010 SHALL have port busy, output, 1 bit: high while in BUSY.
REQ-011 SHALL have port timeout, output, 1 bit: one-cycle pulse on a timeout abort.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-013 In IDLE with at least one m_req valid high, SHALL select one master by round-robin and register it into grant.
  - Search starts at index ptr and wraps modulo N_MASTERS.
  - The FSM goes to BUSY on the next edge.
REQ-014 In IDLE with no valid high, SHALL stay in IDLE with grant=0.
REQ-015 In IDLE, s_req SHALL be all zeros, and every master's ready SHALL be 0.
REQ-016 In BUSY, s_req SHALL equal the granted master's full request, combinationally.
REQ-017 Non-granted masters' requests SHALL have no effect on s_req.
REQ-018 In BUSY, the granted master's m_resp SHALL equal s_resp.
REQ-019 Non-granted masters SHALL see ready=0; rdata SHALL be broadcast to all masters.
REQ-020 Completion: in BUSY with s_resp ready=1, the transfer completes in that cycle.
  - Next state: IDLE.
  - ptr <= (granted index + 1) mod N_MASTERS.
  - Counter cleared.
REQ-021 If the granted master drops valid while in BUSY before ready, SHALL return to IDLE next cycle.
  - ptr is updated as in REQ-020.
  - No timeout pulse.
REQ-022 A cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle without ready.
REQ-023 When the counter equals TIMEOUT-1 and ready=0, SHALL abort the transfer in that cycle:
  - s_req valid forced to 0.
  - Granted master sees ready=1 and rdata=0.
  - timeout=1 for exactly one cycle, registered so it appears the following cycle.
  - Next state IDLE; ptr updated as in REQ-020.
REQ-024 If ready=1 and the timeout condition coincide in the same cycle, ready SHALL win: normal completion, no timeout pulse.
REQ-025 After each completion or abort, there SHALL be at least one IDLE cycle before the next grant.
  - Minimum grant-to-grant spacing: 2 cycles.
REQ-026 Counter width SHALL be $clog2(TIMEOUT); ptr width SHALL be $clog2(N_MASTERS); ptr wrap from N_MASTERS-1 SHALL go to 0.
REQ-027 The block SHALL guarantee no starvation: any master holding valid is granted within N_MASTERS arbitration rounds.
REQ-028 grant SHALL be one-hot or zero at all times.
REQ-029 busy SHALL equal (state==BUSY).

Reset
REQ-030 When rst=0 at a rising clk edge, SHALL set:
  - state=IDLE, ptr=0, counter=0, grant=0, busy=0, timeout=0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer without issuing ready to any master.
  - s_req valid=0 from the first cycle after the reset edge.
REQ-032 In the first cycle after rst is released, SHALL arbitrate normally from ptr=0.

Verification
Benches use N_MASTERS=3 and TIMEOUT=8.
REQ-033 Reset release, then m0 valid; slave ready 2 cycles after BUSY entry.
  -> grant=001 next cycle; s_req=m0 request.
  -> m0 ready=1 for exactly 1 cycle.
  -> IDLE; ptr=1.
REQ-034 m0, m1 and m2 all valid continuously; slave ready in the first BUSY cycle.
  -> grants in order 001, 010, 100, 001.
  -> Each grant separated by one IDLE cycle.
REQ-035 m2 valid; slave never ready.
  -> On BUSY cycle 8: m2 ready=1, rdata=0, s_req valid=0.
  -> timeout pulse on the next cycle; then IDLE with ptr=0.
REQ-036 Slave ready=1 on BUSY cycle 8, coinciding with the timeout condition.
  -> Normal completion, rdata passed through, timeout stays 0.
REQ-037 m1 granted; rst=0 on BUSY cycle 2.
  -> Next cycle: grant=000, busy=0, s_req valid=0, no ready to m1.
  -> After release, m1 still valid -> grant=010.
REQ-038 m1 granted; m1 drops valid on BUSY cycle 1 while m0 is valid.
  -> IDLE next cycle, then grant=100 is not issued.
  -> grant=001, since ptr=2 and m2 is idle, the search wraps to m0.
